// File: rtl/main.sv
// Nine-state ring sequencer: state k advances to k+1 (8 wraps to 0) only
// while its own enable ik is high; y is the registered state code.
module main (
    input  logic       clock,
    input  logic       reset,
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    input  logic       i4,
    input  logic       i5,
    input  logic       i6,
    input  logic       i7,
    input  logic       i8,
    output logic [3:0] y
);

    typedef enum logic [3:0] {
        S0 = 4'd0,
        S1 = 4'd1,
        S2 = 4'd2,
        S3 = 4'd3,
        S4 = 4'd4,
        S5 = 4'd5,
        S6 = 4'd6,
        S7 = 4'd7,
        S8 = 4'd8
    } state_t;

    // Plain 4-bit register so codes 9..15 remain representable and recoverable.
    logic [3:0] state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S0;
        end else begin
            case (state)
                S0:      if (i0) state <= S1;
                S1:      if (i1) state <= S2;
                S2:      if (i2) state <= S3;
                S3:      if (i3) state <= S4;
                S4:      if (i4) state <= S5;
                S5:      if (i5) state <= S6;
                S6:      if (i6) state <= S7;
                S7:      if (i7) state <= S8;
                S8:      if (i8) state <= S0;
                default: state <= S0;
            endcase
        end
    end

    assign y = state;

endmodule

// File: tb/tb_main.sv
// Randomized and directed checks of the nine-state ring sequencer against
// an arithmetic model of "advance when the current state's enable is high".
module tb_main;

    logic       clock;
    logic       reset;
    logic [8:0] in_v;
    logic [3:0] y;

    int total;
    int bad;
    int ms;

    main dut (
        .clock (clock),
        .reset (reset),
        .i0    (in_v[0]),
        .i1    (in_v[1]),
        .i2    (in_v[2]),
        .i3    (in_v[3]),
        .i4    (in_v[4]),
        .i5    (in_v[5]),
        .i6    (in_v[6]),
        .i7    (in_v[7]),
        .i8    (in_v[8]),
        .y     (y)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: y=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One rising edge: advance the model, then sample y 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clock);
        if (!reset) ms = 0;
        else if (ms > 8) ms = 0;
        else if (in_v[ms]) ms = (ms + 1) % 9;
        #1;
        check_val(tag, y, ms[3:0]);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        ms = 0;
        #1;
        check_val(tag, y, 4'd0);
    endtask

    task automatic release_reset();
        #2;
        reset = 1'b1;
    endtask

    task automatic run_to(input int target, input string tag);
        in_v = '1;
        for (int n = 0; n < 20 && ms != target; n++) tick(tag);
        if (ms != target) check_val({tag, "_timeout"}, y, target[3:0]);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ms    = 0;
        in_v  = '1;
        reset = 1'b0;

        // Reset held for three edges with all enables high
        #1;
        check_val("reset_imm", y, 4'd0);
        for (int n = 0; n < 3; n++) tick("reset_hold");
        release_reset();
        for (int n = 0; n < 20; n++) tick("count_all_ones");

        // Stall in S3 until i3 rises
        async_reset("rst_before_stall");
        release_reset();
        in_v = 9'h1F7;
        for (int n = 0; n < 8; n++) tick("stall_s3");
        check_val("stall_s3_final", y, 4'd3);
        in_v[3] = 1'b1;
        for (int n = 0; n < 5; n++) tick("resume_s3");

        // S0 with i0 low ignores every other enable
        async_reset("rst_before_s0");
        release_reset();
        for (int n = 0; n < 10; n++) begin
            in_v = 9'($urandom) & 9'h1FE;
            tick("s0_ignore");
        end

        // Mid-cycle reset from S6
        run_to(6, "to_s6");
        async_reset("async_from_s6");
        in_v = '1;
        for (int n = 0; n < 3; n++) tick("held_in_reset");
        release_reset();
        tick("after_release_s1");

        // Dwell in S8 then wrap
        run_to(8, "to_s8");
        in_v[8] = 1'b0;
        for (int n = 0; n < 3; n++) begin
            in_v[7:0] = 8'($urandom);
            tick("s8_hold");
        end
        in_v[8] = 1'b1;
        tick("s8_wrap");

        // Illegal code recovers to S0 regardless of inputs
        #2;
        force dut.state = 4'b1101;
        ms = 13;
        #1;
        check_val("forced_illegal", y, 4'd13);
        release dut.state;
        in_v = 9'($urandom);
        tick("illegal_recover");

        // Random enables with occasional asynchronous resets
        for (int n = 0; n < 400; n++) begin
            #2;
            in_v = 9'($urandom);
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b0;
                ms = 0;
                #1;
                check_val("rand_async", y, 4'd0);
            end else begin
                reset = 1'b1;
            end
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 The block SHALL have no parameters; state count (9) and output width (4) are fixed.
REQ-002 The port list SHALL be, in order:
- clock  input  1  sole clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- i0..i8  input  1 each  advance enables; ik is used only while in state Sk.
- y  output  4  current state encoding.
REQ-003 There SHALL be one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL be a Moore FSM with nine states S0..S8, encoded as binary 0..8 (S0=4'b0000 … S8=4'b1000).
REQ-005 y SHALL equal the registered state encoding, with no combinational path from any input to y.
REQ-006 State SHALL update only on a rising clock edge while reset=1.
REQ-007 Transitions from Sk for k=0..7:
- ik=1 -> S(k+1).
- ik=0 -> remain in Sk.
REQ-008 Transitions from S8:
- i8=1 -> S0 (wrap-around).
- i8=0 -> remain in S8.
REQ-009 In any state Sk, all inputs other than ik SHALL be ignored; their toggling SHALL NOT affect state or y.
REQ-010 Latency: an input change is reflected on y exactly one rising edge after it is sampled; at most one state step per clock.
REQ-011 Encodings 9..15 are illegal. If the register ever holds one, the next rising edge (reset=1) SHALL load S0, regardless of inputs.
REQ-012 With all inputs held at 1, y SHALL step 0,1,2,…,8,0,1,… one value per clock, with period 9.
REQ-013 Inputs are synchronous to clock and SHALL be sampled only at the rising edge.

Reset
REQ-014 While reset=0, the state SHALL be S0 and y=4'b0000, immediately and without any clock edge.
REQ-015 Asserting reset mid-operation, from any state, SHALL force S0 asynchronously, overriding all inputs.
REQ-016 After reset goes 1, the first rising edge SHALL evaluate the S0 transition, so y=1 after that edge if i0=1.
REQ-017 Reset SHALL take priority over a simultaneous rising clock edge.

Verification
REQ-018 All inputs=1; hold reset=0 for 3 cycles, then release -> y=0 during reset, then 1,2,…,8,0,1,… on successive edges for at least 15 cycles.
REQ-019 All inputs=1 except i3=0 -> y reaches 3 and stays at 3. Then raise i3 -> y=4 on the next edge and counting resumes.
REQ-020 In S0, set i0=0 and toggle i1..i8 arbitrarily -> y stays 0 on every edge.
REQ-021 Drive reset=0 between clock edges while y=6 -> y=0 before the next edge, and y stays 0 until reset returns to 1.
REQ-022 In S8, set i8=0 for 3 edges -> y=8 throughout. Then set i8=1 -> y=0 on the next edge.
REQ-023 Force the state register to 4'b1101 (bench force/deposit), then release with reset=1 and arbitrary inputs -> y=0 after one edge.
